// File: rtl/tnn_vote_scheduler.sv
// -----------------------------------------------------------------------------
// tnn_vote_scheduler
//
// Time-multiplexes one 10-bit feature sample across NUM_CORES combinational
// single-output classifier cores that share one input bus. The scheduler
// accepts a sample over valid/ready and holds it on core_in. It steps core_sel
// through the cores, giving each one SETTLE+1 cycles, and samples the selected
// core's vote on the last cycle of its slot. The vote vector, the ones-count
// and a thresholded class decision are returned over valid/ready.
//
// Optional feature (macro TNN_VOTE_SCHED_EARLY_EXIT_EN):
//   When defined, evaluation stops as soon as the class decision can no longer
//   change. Cores that are never evaluated report a vote of 0, and out_count
//   covers only the cores that were evaluated.
//
// Parameters:
//   NUM_CORES  cores evaluated per sample (2..16)
//   THRESHOLD  minimum ones-count for out_class=1 (1..NUM_CORES)
//   SETTLE     extra wait cycles per core before sampling core_out (0..7)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   sample available
//   in_ready   scheduler can accept a sample (IDLE only)
//   in_data    packed features a=[1:0] b=[3:2] c=[5:4] d=[7:6] e=[9:8]
//   core_in    registered copy of the accepted sample, driven to all cores
//   core_sel   index of the core under evaluation
//   core_out   vote of the selected core (combinational from core_in/core_sel)
//   busy       high in EVAL or DONE
//   out_valid  result available (DONE)
//   out_ready  consumer takes the result
//   out_votes  bit k = vote of core k
//   out_count  number of ones in out_votes
//   out_class  out_count >= THRESHOLD
// -----------------------------------------------------------------------------
module tnn_vote_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int THRESHOLD = 3,
    parameter int SETTLE    = 0,
    localparam int SEL_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    localparam int CNT_W    = $clog2(NUM_CORES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [9:0]           in_data,
    output logic [9:0]           core_in,
    output logic [SEL_W-1:0]     core_sel,
    input  logic                 core_out,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_CORES-1:0] out_votes,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_class
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] THR         = CNT_W'(THRESHOLD);
    localparam logic [2:0]       SETTLE_LAST = 3'(SETTLE);
    localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NUM_CORES - 1);

    state_t                 state_q, state_d;
    logic [9:0]             core_in_q;
    logic [SEL_W-1:0]       core_sel_q;
    logic [2:0]             settle_q;
    logic [NUM_CORES-1:0]   votes_q;
    logic [CNT_W-1:0]       count_q;

    logic                   accept;
    logic                   slot_end;
    logic                   eval_exit;
    logic [CNT_W-1:0]       count_next;
    logic                   decided;

`ifdef TNN_VOTE_SCHED_EARLY_EXIT_EN
    // Best achievable count if every core after the current one voted 1.
    logic [CNT_W:0]         reach;
`endif

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        accept     = 1'b0;
        slot_end   = 1'b0;
        eval_exit  = 1'b0;
        count_next = count_q + CNT_W'(core_out);

`ifdef TNN_VOTE_SCHED_EARLY_EXIT_EN
        reach   = {1'b0, count_next} + (CNT_W + 1)'(LAST_SEL - core_sel_q);
        // Decision is fixed once the threshold is met or can no longer be met.
        decided = (core_sel_q == LAST_SEL) ||
                  (count_next >= THR) ||
                  (reach < {1'b0, THR});
`else
        decided = (core_sel_q == LAST_SEL);
`endif

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (settle_q == SETTLE_LAST) begin
                    slot_end = 1'b1;
                    if (decided) begin
                        eval_exit = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so all
            // registers update together from the values before the edge.
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_in_q  <= '0;
            core_sel_q <= '0;
            settle_q   <= '0;
            votes_q    <= '0;
            count_q    <= '0;
        end else if (accept) begin
            core_in_q  <= in_data;
            core_sel_q <= '0;
            settle_q   <= '0;
            votes_q    <= '0;
            count_q    <= '0;
        end else if (state_q == EVAL) begin
            if (slot_end) begin
                votes_q[core_sel_q] <= core_out;
                count_q             <= count_next;
                settle_q            <= '0;
                // Park on core 0 when leaving EVAL so no out-of-range index
                // is ever presented to the core mux.
                core_sel_q          <= eval_exit ? '0 : core_sel_q + 1'b1;
            end else begin
                settle_q <= settle_q + 3'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign core_in   = core_in_q;
    assign core_sel  = core_sel_q;
    assign out_votes = votes_q;
    assign out_count = count_q;
    assign out_class = (count_q >= THR);

endmodule

// File: tb/tb_tnn_vote_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tnn_vote_scheduler
//
// Self-checking bench for tnn_vote_scheduler. Two instances share clk/rst_n:
//   u_dut     defaults (NUM_CORES=4, THRESHOLD=3, SETTLE=0); its core bank is
//             modelled as a vote table indexed by core_sel.
//   u_dut_s2  SETTLE=2; its core_out is driven cycle by cycle, showing the true
//             vote only on the last cycle of each slot.
// Expected values are hand-computed and follow TNN_VOTE_SCHED_EARLY_EXIT_EN.
// -----------------------------------------------------------------------------
module tb_tnn_vote_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;

    // Default instance
    logic       in_valid, in_ready, core_out, busy, out_valid, out_ready, out_class;
    logic [9:0] in_data, core_in;
    logic [1:0] core_sel;
    logic [3:0] out_votes;
    logic [2:0] out_count;
    logic [3:0] model_votes;

    // SETTLE=2 instance
    logic       s2_in_valid, s2_in_ready, s2_core_out, s2_busy, s2_out_valid;
    logic       s2_out_ready, s2_out_class;
    logic [9:0] s2_in_data, s2_core_in;
    logic [1:0] s2_core_sel;
    logic [3:0] s2_out_votes;
    logic [2:0] s2_out_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign core_out = model_votes[core_sel];

    tnn_vote_scheduler u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .core_in   (core_in),
        .core_sel  (core_sel),
        .core_out  (core_out),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_votes (out_votes),
        .out_count (out_count),
        .out_class (out_class)
    );

    tnn_vote_scheduler #(.SETTLE(2)) u_dut_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s2_in_valid),
        .in_ready  (s2_in_ready),
        .in_data   (s2_in_data),
        .core_in   (s2_core_in),
        .core_sel  (s2_core_sel),
        .core_out  (s2_core_out),
        .busy      (s2_busy),
        .out_valid (s2_out_valid),
        .out_ready (s2_out_ready),
        .out_votes (s2_out_votes),
        .out_count (s2_out_count),
        .out_class (s2_out_class)
    );

    typedef struct {
        logic [9:0] data;
        logic [3:0] votes;      // bit k = vote returned by core k
        logic [3:0] exp_votes;
        logic [2:0] exp_count;
        logic       exp_class;
        int         exp_lat;    // edges from accepting edge (inclusive) to out_valid
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Accept one sample on the default instance, wait for the result, check it
    // and complete the output handshake. Entered and left #1 after an edge.
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        model_votes = v.votes;
        in_data     = v.data;
        in_valid    = 1'b1;
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~v.data;   // must be ignored while busy
        check({tag, " busy"}, 32'(busy), 32'd1);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"},   32'(lat),       32'(v.exp_lat));
        check({tag, " out_votes"}, 32'(out_votes), 32'(v.exp_votes));
        check({tag, " out_count"}, 32'(out_count), 32'(v.exp_count));
        check({tag, " out_class"}, 32'(out_class), 32'(v.exp_class));
        check({tag, " core_in"},   32'(core_in),   32'(v.data));
        check({tag, " in_ready done"}, 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready back"},  32'(in_ready),  32'd1);
        check({tag, " core_sel park"},  32'(core_sel),  32'd0);
    endtask

    initial begin
        int errs;
        int lat;
        logic [3:0] s2_votes;

        // Hand-computed vectors: {data, votes, exp_votes, exp_count, exp_class, exp_lat}
`ifdef TNN_VOTE_SCHED_EARLY_EXIT_EN
        vecs[0] = '{10'h2B5, 4'b1101, 4'b1101, 3'd3, 1'b1, 5};
        vecs[1] = '{10'h155, 4'b1001, 4'b0001, 3'd1, 1'b0, 4};
        vecs[2] = '{10'h3FF, 4'b1111, 4'b0111, 3'd3, 1'b1, 4};
        vecs[3] = '{10'h0AA, 4'b1100, 4'b0000, 3'd0, 1'b0, 3};
        vecs[4] = '{10'h000, 4'b0000, 4'b0000, 3'd0, 1'b0, 3};
        vecs[5] = '{10'h2C3, 4'b1110, 4'b1110, 3'd3, 1'b1, 5};
`else
        vecs[0] = '{10'h2B5, 4'b1101, 4'b1101, 3'd3, 1'b1, 5};
        vecs[1] = '{10'h155, 4'b1001, 4'b1001, 3'd2, 1'b0, 5};
        vecs[2] = '{10'h3FF, 4'b1111, 4'b1111, 3'd4, 1'b1, 5};
        vecs[3] = '{10'h0AA, 4'b1100, 4'b1100, 3'd2, 1'b0, 5};
        vecs[4] = '{10'h000, 4'b0000, 4'b0000, 3'd0, 1'b0, 5};
        vecs[5] = '{10'h2C3, 4'b1110, 4'b1110, 3'd3, 1'b1, 5};
`endif

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        model_votes  = '0;
        s2_in_valid  = 1'b0;
        s2_in_data   = '0;
        s2_out_ready = 1'b0;
        s2_core_out  = 1'b0;

        // ---- Reset state -----------------------------------------------------
        #1;
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst busy",      32'(busy),      32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst core_in",   32'(core_in),   32'd0);
        check("rst out_count", 32'(out_count), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // ---- Table-driven vectors -------------------------------------------
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // ---- Reset mid-EVAL --------------------------------------------------
        model_votes = 4'b1111;
        in_data     = 10'h1F0;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid busy before reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst in_ready",  32'(in_ready),  32'd1);
        check("mid rst busy",      32'(busy),      32'd0);
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst core_in",   32'(core_in),   32'd0);
        check("mid rst core_sel",  32'(core_sel),  32'd0);
        check("mid rst out_votes", 32'(out_votes), 32'd0);
        check("mid rst out_count", 32'(out_count), 32'd0);
        check("mid rst out_class", 32'(out_class), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        errs = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid || busy) errs++;
        end
        check("mid rst no result", 32'(errs), 32'd0);

        // ---- Backpressure in DONE --------------------------------------------
        model_votes = 4'b1101;
        in_data     = 10'h2B5;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp reached done", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        in_data  = 10'h0F0;
        errs = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_votes !== 4'b1101 ||
                out_count !== 3'd3 || out_class !== 1'b1 || core_in !== 10'h2B5)
                errs++;
        end
        check("bp frozen 10 cycles", 32'(errs), 32'd0);
        model_votes = 4'b0000;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp out_valid drop", 32'(out_valid), 32'd0);
        check("bp in_ready",       32'(in_ready),  32'd1);
        check("bp not accepted",   32'(core_in),   32'h2B5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp next accepted", 32'(core_in), 32'h0F0);
        check("bp next busy",     32'(busy),    32'd1);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp next count", 32'(out_count), 32'd0);
        check("bp next class", 32'(out_class), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // ---- SETTLE=2: only the last cycle of each slot is sampled ------------
        s2_votes    = 4'b0110;
        s2_in_data  = 10'h2B5;
        s2_in_valid = 1'b1;
        check("s2 in_ready", 32'(s2_in_ready), 32'd1);
        @(posedge clk); #1;
        s2_in_valid = 1'b0;
        errs = 0;
        for (int j = 0; j < 12; j++) begin
            if (s2_core_sel !== 2'(j / 3) || s2_out_valid !== 1'b0) errs++;
            s2_core_out = (j % 3 == 2) ? s2_votes[j / 3] : ~s2_votes[j / 3];
            @(posedge clk); #1;
        end
        check("s2 sel hold and no early valid", 32'(errs), 32'd0);
        check("s2 latency 13",  32'(s2_out_valid), 32'd1);
        check("s2 out_votes",   32'(s2_out_votes), 32'h6);
        check("s2 out_count",   32'(s2_out_count), 32'd2);
        check("s2 out_class",   32'(s2_out_class), 32'd0);
        check("s2 core_in",     32'(s2_core_in),   32'h2B5);
        s2_out_ready = 1'b1;
        @(posedge clk); #1;
        s2_out_ready = 1'b0;
        check("s2 out_valid drop", 32'(s2_out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
